// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: carries pc/alu/reg2/dest plus wb/mem control bits one stage forward.
// Latency: 1 cycle from an input handshake to out_valid when the stage is empty; with back-to-back handshakes it moves one instruction per cycle.
// Backpressure: the default build drives in_ready = (!out_valid | out_ready) & !flush. Defining PIPE_STAGE_SKID_EN adds a skid entry, and then in_ready = !skid_valid & !flush.
module pipe_stage_reg #(
   parameter int PC_W   = 32,
   parameter int DATA_W = 32,
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   // upstream
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_reg2,
   input  logic [DEST_W-1:0] in_dest,
   input  logic              in_wb_en,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   // pipeline kill
   input  logic              flush,
   // downstream
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_reg2,
   output logic [DEST_W-1:0] out_dest,
   output logic              out_wb_en,
   output logic              out_mem_read,
   output logic              out_mem_write
);

   // One held instruction. The control bits come last so a bubble can clear them alone.
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] reg2;
      logic [DEST_W-1:0] dest;
      logic              wb_en;
      logic              mem_read;
      logic              mem_write;
   } entry_t;

   // Turns an entry into a bubble. The control bits drop to 0 and the data fields stay as they were,
   // so a killed slot keeps stable data and cannot cause a write or a memory access.
   function automatic entry_t f_bubble(input entry_t e);
      entry_t r;
      r           = e;
      r.wb_en     = 1'b0;
      r.mem_read  = 1'b0;
      r.mem_write = 1'b0;
      return r;
   endfunction

   entry_t r_main;
   logic   r_main_vld;
   entry_t w_in_ent;
   logic   w_in_hs;
   logic   w_out_hs;

   assign w_in_ent.pc        = in_pc;
   assign w_in_ent.alu       = in_alu;
   assign w_in_ent.reg2      = in_reg2;
   assign w_in_ent.dest      = in_dest;
   assign w_in_ent.wb_en     = in_wb_en;
   assign w_in_ent.mem_read  = in_mem_read;
   assign w_in_ent.mem_write = in_mem_write;

   assign w_in_hs  = in_valid & in_ready;
   assign w_out_hs = r_main_vld & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   entry_t r_skid;
   logic   r_skid_vld;

   // in_ready comes only from state and flush. No path runs from out_ready to in_ready.
   assign in_ready = ~r_skid_vld & ~flush;

   // Main entry: refill from skid first so order holds, else take the new input, else drain to a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_vld <= 1'b0;
         r_main     <= '0;
      end else if (flush) begin
         r_main_vld <= 1'b0;
         r_main     <= f_bubble(r_main);
      end else if (!r_main_vld || w_out_hs) begin
         if (r_skid_vld) begin
            r_main_vld <= 1'b1;
            r_main     <= r_skid;
         end else if (w_in_hs) begin
            r_main_vld <= 1'b1;
            r_main     <= w_in_ent;
         end else begin
            r_main_vld <= 1'b0;
            r_main     <= f_bubble(r_main);
         end
      end
   end

   // Skid entry: catches an input accepted while main is stalled, and empties when main moves out.
   // While the skid entry is full, in_ready is 0, so no new input can arrive in the same cycle it moves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_skid_vld <= 1'b0;
         r_skid     <= '0;
      end else if (flush) begin
         r_skid_vld <= 1'b0;
         r_skid     <= f_bubble(r_skid);
      end else if (r_skid_vld && w_out_hs) begin
         r_skid_vld <= 1'b0;
         r_skid     <= f_bubble(r_skid);
      end else if (r_main_vld && !w_out_hs && w_in_hs) begin
         r_skid_vld <= 1'b1;
         r_skid     <= w_in_ent;
      end
   end
`else
   // A full stage still accepts when downstream drains in the same cycle, which keeps full throughput.
   assign in_ready = (~r_main_vld | out_ready) & ~flush;

   // Main entry order: flush kills it, a new input replaces it, a drain with no refill leaves a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_vld <= 1'b0;
         r_main     <= '0;
      end else if (flush) begin
         r_main_vld <= 1'b0;
         r_main     <= f_bubble(r_main);
      end else if (w_in_hs) begin
         r_main_vld <= 1'b1;
         r_main     <= w_in_ent;
      end else if (w_out_hs) begin
         r_main_vld <= 1'b0;
         r_main     <= f_bubble(r_main);
      end
   end
`endif

   assign out_valid     = r_main_vld;
   assign out_pc        = r_main.pc;
   assign out_alu       = r_main.alu;
   assign out_reg2      = r_main.reg2;
   assign out_dest      = r_main.dest;
   assign out_wb_en     = r_main.wb_en;
   assign out_mem_read  = r_main.mem_read;
   assign out_mem_write = r_main.mem_write;

endmodule
